// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 convolution over a raster-order pixel stream.
// Two line buffers plus a 3x3 window register form the neighbourhood; a
// four-stage pipeline (products, row sums, total, shift/saturate/relu)
// produces one result per completed interior window.
module conv3x3_stream #(
    parameter int DATA_W = 4,
    parameter int COEF_W = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   pix_in,
    input  logic                pix_valid,
    input  logic                coef_wr,
    input  logic [3:0]          coef_addr,
    input  logic [COEF_W-1:0]   coef_data,
    input  logic                relu_en,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    output logic                frame_done
);

    // Unsigned pixel times signed coefficient always fits in DATA_W+COEF_W bits.
    localparam int PW   = DATA_W + COEF_W;
    localparam int RW   = PW + 2;
    localparam int SW   = PW + 4;
    localparam int LB   = IMG_W - 1;
    localparam int CW   = $clog2(IMG_W);
    localparam int HW   = $clog2(IMG_H);
    localparam int OMAX = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN = -(1 << (OUT_W - 1));

    logic signed [COEF_W-1:0] coef [0:8];
    logic [CW-1:0]            col_cnt;
    logic [HW-1:0]            row_cnt;
    logic [DATA_W-1:0]        lb1 [0:LB-1];
    logic [DATA_W-1:0]        lb2 [0:LB-1];
    logic [DATA_W-1:0]        win [0:2][0:2];
    logic signed [PW-1:0]     prod [0:8];
    logic signed [RW-1:0]     rsum [0:2];
    logic signed [SW-1:0]     total;
    logic                     v0, v1, v2, v3;
    logic                     l0, l1, l2, l3;
    logic                     win_ok, last_pix;
    logic signed [SW-1:0]     shifted;
    logic signed [31:0]       sh32;
    logic [OUT_W-1:0]         res;

    function automatic logic signed [COEF_W-1:0] cross_val(input int i);
        return (i == 1 || i == 3 || i == 4 || i == 5 || i == 7) ? COEF_W'(1) : '0;
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic [DATA_W-1:0] p,
                                                 input logic signed [COEF_W-1:0] c);
        logic signed [PW-1:0] pe;
        logic signed [PW-1:0] ce;
        pe = PW'($signed({1'b0, p}));
        ce = PW'(c);
        return pe * ce;
    endfunction

    assign win_ok   = (row_cnt >= HW'(2)) && (col_cnt >= CW'(2));
    assign last_pix = (row_cnt == HW'(IMG_H - 1)) && (col_cnt == CW'(IMG_W - 1));

    // Coefficient register file; reset restores the cross kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) coef[i] <= cross_val(i);
        end else if (coef_wr) begin
            for (int i = 0; i < 9; i++)
                if (coef_addr == 4'(i)) coef[i] <= coef_data;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_valid) begin
            if (col_cnt == CW'(IMG_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == HW'(IMG_H - 1)) ? '0 : row_cnt + HW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // Window and line buffers; the newest window column enters at index 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LB; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win[r][c] <= '0;
        end else if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[2][2] <= pix_in;
            win[1][2] <= lb1[LB-1];
            win[0][2] <= lb2[LB-1];
            lb1[0]    <= win[2][2];
            lb2[0]    <= win[1][2];
            for (int i = 1; i < LB; i++) begin
                lb1[i] <= lb1[i-1];
                lb2[i] <= lb2[i-1];
            end
        end
    end

    // Valid and end-of-frame flags travelling alongside the data pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            {v0, v1, v2, v3} <= '0;
            {l0, l1, l2, l3} <= '0;
        end else begin
            v0 <= pix_valid && win_ok;
            l0 <= pix_valid && last_pix;
            v1 <= v0;
            v2 <= v1;
            v3 <= v2;
            l1 <= l0;
            l2 <= l1;
            l3 <= l2;
        end
    end

    // Stages 1-3: products, row sums, total.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) prod[i] <= mul(win[i/3][i%3], coef[i]);
        for (int r = 0; r < 3; r++)
            rsum[r] <= RW'(prod[3*r]) + RW'(prod[3*r+1]) + RW'(prod[3*r+2]);
        total <= SW'(rsum[0]) + SW'(rsum[1]) + SW'(rsum[2]);
    end

    // Stage 4 combinational: shift, saturate, optional relu.
    always_comb begin
        shifted = total >>> SHIFT;
        sh32    = 32'(shifted);
        res     = OUT_W'(sh32);
        if (sh32 > OMAX)      res = OUT_W'(OMAX);
        else if (sh32 < OMIN) res = OUT_W'(OMIN);
        if (relu_en && res[OUT_W-1]) res = '0;
    end

    // Output register; data holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= v3;
            frame_done <= l3;
            if (v3) out_data <= res;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Testbench for conv3x3_stream: directed table of frames with hand-derived
// results, randomized frames against an image-array reference model, and a
// mid-frame reset sequence.
module tb_conv3x3_stream;

    localparam int DW = 4;
    localparam int KW = 4;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int OW = 8;
    localparam int SH = 0;
    localparam int NRES = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          coef_wr = 1'b0;
    logic [3:0]    coef_addr = '0;
    logic [KW-1:0] coef_data = '0;
    logic          relu_en = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          frame_done;

    conv3x3_stream #(.DATA_W(DW), .COEF_W(KW), .IMG_W(W), .IMG_H(H),
                     .OUT_W(OW), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .relu_en(relu_en), .out_data(out_data), .out_valid(out_valid),
        .frame_done(frame_done));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int first_edge = -1;
    int acc18 = -1;
    int orphan = 0;
    int hold_err = 0;
    bit have_last = 0;
    logic [OW-1:0] last_out = '0;

    int got_q[$];
    bit got_fd[$];
    int exp_q[$];
    bit exp_fd[$];

    int mk[9];
    int img[H][W];
    int m_row = 0;
    int m_col = 0;

    typedef struct {
        string       name;
        logic [35:0] k;
        int          pix;
        bit          relu;
        bit          alt;
        int          frames;
        bit          wr;
        int          exp_val;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back(int'($signed(out_data)));
            got_fd.push_back(frame_done);
            if (first_edge < 0) first_edge = cyc;
            last_out = out_data;
        end else begin
            if (frame_done) orphan++;
            if (!rst && have_last && out_data !== last_out) hold_err++;
        end
        if (rst) have_last = 0;
        else if (out_valid) have_last = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic vec_t mkv(string n, logic [35:0] k, int pix, bit relu, bit alt,
                                 int fr, bit wr, int ev, int ec);
        vec_t v;
        v.name = n; v.k = k; v.pix = pix; v.relu = relu; v.alt = alt;
        v.frames = fr; v.wr = wr; v.exp_val = ev; v.exp_cnt = ec;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 9; i++)
            mk[i] = (i == 1 || i == 3 || i == 4 || i == 5 || i == 7) ? 1 : 0;
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic int model_out(int r, int c);
        int s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += img[r-2+dr][c-2+dc] * mk[dr*3+dc];
        s = s >>> SH;
        if (s > (1 << (OW-1)) - 1) s = (1 << (OW-1)) - 1;
        if (s < -(1 << (OW-1)))    s = -(1 << (OW-1));
        if (relu_en && s < 0) s = 0;
        return s;
    endfunction

    function automatic void model_pixel(int px);
        img[m_row][m_col] = px;
        if (m_row * W + m_col == 18 && acc18 < 0) acc18 = cyc + 1;
        if (m_row >= 2 && m_col >= 2) begin
            exp_q.push_back(model_out(m_row, m_col));
            exp_fd.push_back(m_row == H-1 && m_col == W-1);
        end
        if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endfunction

    // One clock of stimulus; applied just after a rising edge, accepted at the next.
    task automatic step(input logic pv, input logic [3:0] px, input logic cw,
                        input logic [3:0] ca, input logic [3:0] cd);
        @(posedge clk); #1;
        pix_valid = pv; pix_in = px; coef_wr = cw; coef_addr = ca; coef_data = cd;
        if (!rst) begin
            if (cw && ca < 9) mk[ca] = int'($signed(cd));
            if (pv) model_pixel(int'(px));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic clear_cap();
        got_q.delete(); got_fd.delete(); exp_q.delete(); exp_fd.delete();
        first_edge = -1;
        acc18 = -1;
    endtask

    task automatic do_reset(input int n, input string name);
        @(posedge clk); #1;
        rst = 1'b1; pix_valid = 1'b1; pix_in = 4'hF;
        coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 4'h7;
        repeat (n) begin
            @(posedge clk); @(negedge clk);
            chk({name, " rst out_valid"}, int'(out_valid), 0);
            chk({name, " rst frame_done"}, int'(frame_done), 0);
            chk({name, " rst out_data"}, int'(out_data), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; pix_valid = 1'b0; coef_wr = 1'b0;
        model_reset();
    endtask

    task automatic check_run(input string name, input bit use_const, input int cval,
                             input int ccnt, input int frames);
        int nexp;
        int nfd = 0;
        int efd = 0;
        nexp = use_const ? ccnt : exp_q.size();
        chk({name, " count"}, got_q.size(), nexp);
        for (int i = 0; i < got_q.size() && i < nexp; i++) begin
            chk($sformatf("%s val[%0d]", name, i), got_q[i], use_const ? cval : exp_q[i]);
            chk($sformatf("%s fd[%0d]", name, i), int'(got_fd[i]),
                use_const ? int'(i % NRES == NRES - 1) : int'(exp_fd[i]));
        end
        foreach (got_fd[i]) nfd += int'(got_fd[i]);
        foreach (exp_fd[i]) efd += int'(exp_fd[i]);
        chk({name, " frame_done count"}, nfd, use_const ? frames : efd);
    endtask

    task automatic run_vec(input vec_t v);
        clear_cap();
        @(posedge clk); #1;
        relu_en = v.relu;
        if (v.wr)
            for (int i = 0; i < 9; i++) step(1'b0, 4'h0, 1'b1, 4'(i), v.k[4*i +: 4]);
        for (int f = 0; f < v.frames; f++)
            for (int p = 0; p < W * H; p++) begin
                step(1'b1, 4'(v.pix), 1'b0, 4'h0, 4'h0);
                if (v.alt) idle(1);
            end
        idle(8);
        check_run(v.name, 1'b1, v.exp_val, v.exp_cnt, v.frames);
        chk({v.name, " latency"}, first_edge - acc18, 4);
    endtask

    initial begin
        model_reset();
        tbl[0] = mkv("dflt", 36'h0, 3, 0, 0, 1, 0, 15, NRES);
        tbl[1] = mkv("alt",  36'h0, 3, 0, 1, 1, 0, 15, NRES);
        tbl[2] = mkv("b2b",  36'h0, 3, 0, 0, 2, 0, 15, 2 * NRES);
        tbl[3] = mkv("sat",  36'h111111111, 15, 0, 0, 1, 1, 127, NRES);
        tbl[4] = mkv("neg",  36'h000080000, 15, 0, 0, 1, 1, -120, NRES);
        tbl[5] = mkv("relu", 36'h000080000, 15, 1, 0, 1, 1, 0, NRES);

        do_reset(3, "init");

        for (int t = 0; t < 6; t++) run_vec(tbl[t]);

        for (int n = 0; n < 4; n++) begin
            clear_cap();
            @(posedge clk); #1;
            relu_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 9; i++)
                step(1'b0, 4'h0, 1'b1, 4'(i), 4'($urandom));
            step(1'b0, 4'h0, 1'b1, 4'($urandom_range(9, 15)), 4'($urandom));
            for (int p = 0; p < W * H; p++) begin
                if ($urandom_range(0, 7) == 0)
                    step(1'b1, 4'($urandom), 1'b1, 4'($urandom), 4'($urandom));
                else
                    step(1'b1, 4'($urandom), 1'b0, 4'h0, 4'h0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            idle(8);
            check_run($sformatf("rnd%0d", n), 1'b0, 0, 0, 1);
        end

        // Abort a frame after 30 pixels; results in flight must vanish.
        @(posedge clk); #1;
        relu_en = 1'b0;
        for (int p = 0; p < 30; p++) step(1'b1, 4'd3, 1'b0, 4'h0, 4'h0);
        do_reset(2, "abort");
        @(posedge clk); @(negedge clk);
        chk("abort post-rst out_valid", int'(out_valid), 0);
        clear_cap();
        for (int p = 0; p < W * H; p++) step(1'b1, 4'd3, 1'b0, 4'h0, 4'h0);
        idle(8);
        check_run("abort", 1'b1, 15, NRES, 1);

        chk("orphan frame_done", orphan, 0);
        chk("out_data hold", hold_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 Parameter DATA_W, default 4: unsigned input pixel width.
REQ-002 Parameter COEF_W, default 4: signed two's-complement coefficient width.
REQ-003 Parameter IMG_W, default 8: image columns, minimum 3.
REQ-004 Parameter IMG_H, default 8: image rows, minimum 3.
REQ-005 Parameter OUT_W, default 8: signed output width.
REQ-006 Parameter SHIFT, default 0: arithmetic right shift applied to the sum before saturation.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 pix_in  input  DATA_W  pixel in raster order (row-major, column 0 first).
REQ-010 pix_valid  input  1  qualifies pix_in; the pixel is accepted on every rising edge where it is high; no backpressure.
REQ-011 coef_wr  input  1  coefficient write strobe.
REQ-012 coef_addr  input  4  kernel index 0..8, row-major (0 = top-left, 4 = centre); writes to 9..15 are ignored.
REQ-013 coef_data  input  COEF_W  coefficient value to write.
REQ-014 relu_en  input  1  when high, negative results are clamped to 0.
REQ-015 out_data  output  OUT_W  convolution result (signed).
REQ-016 out_valid  output  1  qualifies out_data; one-cycle pulse per result.
REQ-017 frame_done  output  1  one-cycle pulse, coincident with the last out_valid of each frame.

Function
REQ-018 Two line buffers of IMG_W-1 entries each, plus a 3x3 window register, shall hold the current 3x3 neighbourhood; they shift only on accepted pixels.
REQ-019 A column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) shall advance on each accepted pixel.
REQ-020 Column wrap shall increment the row; row wrap after the last pixel of a frame shall return both counters to 0 for the next frame, with no idle cycle required between frames.
REQ-021 A window is valid only when the accepted pixel has row>=2 and col>=2, giving (IMG_W-2)*(IMG_H-2) outputs per frame; border outputs are never produced.
REQ-022 Pipeline stage 1 shall register nine products pixel*coef, full precision, with each pixel zero-extended.
REQ-023 Pipeline stage 2 shall register three row sums.
REQ-024 Pipeline stage 3 shall register the total sum, full precision (DATA_W+COEF_W+4 bits, signed).
REQ-025 Pipeline stage 4 shall arithmetic-shift right by SHIFT, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], apply ReLU if relu_en is high, and register the result into out_data.
REQ-026 Latency shall be exactly 4 cycles: out_valid rises on the 4th rising edge after the edge that accepted the window-completing pixel.
REQ-027 The pipeline shall advance every cycle regardless of pix_valid; a valid flag travels with each stage, so input gaps produce output gaps and never duplicate or drop results.
REQ-028 Throughput shall be one result per cycle when pix_valid is held high.
REQ-029 out_data shall hold its last value while out_valid is low.
REQ-030 A coefficient write shall take effect for products registered on the cycle after the write edge; simultaneous coef_wr and pix_valid are both honoured.
REQ-031 relu_en shall be sampled at stage 4.
REQ-032 Coefficient reset values shall form the cross kernel: indices 1, 3, 4, 5 and 7 equal 1; indices 0, 2, 6 and 8 equal 0.

Reset
REQ-033 While rst is high, the following shall all be cleared: out_data to 0, out_valid to 0, frame_done to 0, row and column counters to 0, all pipeline valid flags, and the window and line buffers to 0.
REQ-034 While rst is high, coefficients shall return to the REQ-032 values.
REQ-035 Reset mid-frame shall discard all in-flight results: no out_valid in the cycle after rst falls, and the next accepted pixel shall be treated as row 0, column 0.
REQ-036 rst shall override pix_valid and coef_wr in the same cycle.

Verification (IMG_W=8, IMG_H=8, defaults otherwise)
REQ-037 Default coefficients, 64 pixels of 3 with pix_valid held high -> 36 out_valid pulses, each out_data=15; the first pulse arrives 4 cycles after pixel index 18 is accepted; frame_done coincides with the 36th pulse only.
REQ-038 All nine coefficients written to 1, pixels all 15 -> sum 135, out_data=127 (saturated) for all 36 results.
REQ-039 Only coefficient 4 = -8 (others 0), pixels 15, relu_en=0 -> out_data=-120 for all results; repeat with relu_en=1 -> out_data=0 for all results.
REQ-040 REQ-037 stimulus with pix_valid high on alternate cycles -> same 36 values, no extra or missing out_valid, frame_done exactly once.
REQ-041 Assert rst after 30 accepted pixels, then send a full frame of 3s -> no out_valid from the aborted frame; exactly 36 results of 15 follow.
REQ-042 Two back-to-back frames of 3s with no gap -> 72 results of 15 and exactly two frame_done pulses, 36 results apart.
